// File: rtl/aes_key_arbiter.sv
// Round-robin arbiter giving two requesters access to one AES key-expansion engine.
// A single cached key/owner pair lets a repeated key finish without re-expansion.
module aes_key_arbiter #(
  parameter int KEY_WIDTH = 256,
  parameter int TIMEOUT   = 127
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           req_i,
  input  logic [KEY_WIDTH-1:0] key0_i,
  input  logic [KEY_WIDTH-1:0] key1_i,
  input  logic                 flush_i,
  output logic [1:0]           done_o,
  output logic [1:0]           err_o,
  output logic                 busy_o,
  output logic                 owner_o,
  output logic                 owner_valid_o,
  output logic [KEY_WIDTH-1:0] exp_key_o,
  output logic                 exp_key_valid_o,
  input  logic                 exp_keys_valid_i
);

  localparam int CW = (TIMEOUT < 4) ? 2 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MASK = CW'(2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t               r_state, w_state_next;
  logic [1:0]           r_done, w_done_next;
  logic [1:0]           r_err, w_err_next;
  logic                 r_busy, w_busy_next;
  logic                 r_owner, w_owner_next;
  logic                 r_owner_valid, w_owner_valid_next;
  logic [KEY_WIDTH-1:0] r_exp_key, w_exp_key_next;
  logic                 r_exp_key_valid, w_exp_key_valid_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic                 r_last_grant, w_last_grant_next;
  logic                 r_grant, w_grant_next;
  logic                 r_success, w_success_next;

  logic                 w_req_any, w_pick, w_hit, w_accept, w_timeout;
  logic [KEY_WIDTH-1:0] w_pick_key;

  assign w_req_any  = |req_i;
  assign w_pick     = (req_i == 2'b11) ? ~r_last_grant : req_i[1];
  assign w_pick_key = w_pick ? key1_i : key0_i;
  // r_exp_key doubles as the cache: it always holds the last key sent for expansion
  assign w_hit      = r_owner_valid && (w_pick_key == r_exp_key);
  // The engine's valid level is stale for the first two WAIT cycles after a new start
  assign w_accept   = exp_keys_valid_i && (r_cnt >= CNT_MASK);
  assign w_timeout  = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_done          <= 2'b00;
      r_err           <= 2'b00;
      r_busy          <= 1'b0;
      r_owner         <= 1'b0;
      r_owner_valid   <= 1'b0;
      r_exp_key       <= '0;
      r_exp_key_valid <= 1'b0;
      r_cnt           <= '0;
      r_last_grant    <= 1'b1;
      r_grant         <= 1'b0;
      r_success       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_done          <= w_done_next;
      r_err           <= w_err_next;
      r_busy          <= w_busy_next;
      r_owner         <= w_owner_next;
      r_owner_valid   <= w_owner_valid_next;
      r_exp_key       <= w_exp_key_next;
      r_exp_key_valid <= w_exp_key_valid_next;
      r_cnt           <= w_cnt_next;
      r_last_grant    <= w_last_grant_next;
      r_grant         <= w_grant_next;
      r_success       <= w_success_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_next = w_hit ? S_DONE : S_WAIT;
      S_WAIT:  if (w_accept || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done_next          = 2'b00;
    w_err_next           = 2'b00;
    w_owner_next         = r_owner;
    w_owner_valid_next   = r_owner_valid;
    w_exp_key_next       = r_exp_key;
    w_exp_key_valid_next = r_exp_key_valid;
    w_cnt_next           = r_cnt;
    w_last_grant_next    = r_last_grant;
    w_grant_next         = r_grant;
    w_success_next       = r_success;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_grant_next = w_pick;
          if (w_hit) begin
            w_owner_next   = w_pick;
            w_success_next = 1'b1;
          end else begin
            w_exp_key_next       = w_pick_key;
            w_exp_key_valid_next = 1'b1;
            w_owner_valid_next   = 1'b0;
            w_cnt_next           = '0;
            w_success_next       = 1'b0;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = w_timeout ? r_cnt : r_cnt + 1'b1;
        // Acceptance is tested first so it wins over a simultaneous timeout
        if (w_accept) begin
          w_owner_next         = r_grant;
          w_owner_valid_next   = 1'b1;
          w_exp_key_valid_next = 1'b0;
          w_success_next       = 1'b1;
        end else if (w_timeout) begin
          w_exp_key_valid_next = 1'b0;
          w_success_next       = 1'b0;
        end
      end
      S_DONE: begin
        w_done_next          = {r_grant, ~r_grant} & {2{r_success}};
        w_err_next           = {r_grant, ~r_grant} & {2{~r_success}};
        w_last_grant_next    = r_grant;
        w_exp_key_valid_next = 1'b0;
      end
      default: ;
    endcase
    if (flush_i) w_owner_valid_next = 1'b0;
  end

  assign w_busy_next = (w_state_next != S_IDLE);

  assign done_o          = r_done;
  assign err_o           = r_err;
  assign busy_o          = r_busy;
  assign owner_o         = r_owner;
  assign owner_valid_o   = r_owner_valid;
  assign exp_key_o       = r_exp_key;
  assign exp_key_valid_o = r_exp_key_valid;

endmodule

// File: tb/tb_aes_key_arbiter.sv
// Scoreboard bench for aes_key_arbiter: directed jobs push expected responses,
// a negedge monitor pops and compares them whenever done_o/err_o pulses.
module tb_aes_key_arbiter;

  localparam int KW = 256;
  typedef logic [KW-1:0] key_t;
  typedef struct {
    logic [1:0] done;
    logic [1:0] err;
    logic       owner;
    logic       ov;
    key_t       key;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req_i;
  key_t       key0_i, key1_i;
  logic       flush_i = 1'b0;
  logic [1:0] done_o, err_o;
  logic       busy_o, owner_o, owner_valid_o;
  key_t       exp_key_o;
  logic       exp_key_valid_o;
  logic       exp_keys_valid_i = 1'b0;

  aes_key_arbiter #(.KEY_WIDTH(KW), .TIMEOUT(127)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_i            (req_i),
    .key0_i           (key0_i),
    .key1_i           (key1_i),
    .flush_i          (flush_i),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o),
    .owner_o          (owner_o),
    .owner_valid_o    (owner_valid_o),
    .exp_key_o        (exp_key_o),
    .exp_key_valid_o  (exp_key_valid_o),
    .exp_keys_valid_i (exp_keys_valid_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input key_t act, input key_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: scoreboard pops on every completion pulse, plus start-gap tracking
  logic ev_prev = 1'b0;
  logic ev_had_high = 1'b0;
  int   ev_low_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      ev_prev = 1'b0;
      ev_had_high = 1'b0;
      ev_low_run = 0;
    end else begin
      if ((done_o | err_o) != 2'b00) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse: got done=%b err=%b required no pulse", done_o, err_o);
        end else begin
          e = sb_q.pop_front();
          $display("txn cyc=%0d done=%b err=%b owner=%b ov=%b", cyc, done_o, err_o, owner_o, owner_valid_o);
          check("resp_done", KW'(done_o), KW'(e.done));
          check("resp_err", KW'(err_o), KW'(e.err));
          check("resp_owner", KW'(owner_o), KW'(e.owner));
          check("resp_owner_valid", KW'(owner_valid_o), KW'(e.ov));
          check("resp_exp_key", exp_key_o, e.key);
          if (e.cyc >= 0) check("resp_cycle", KW'(cyc), KW'(e.cyc));
        end
      end
      if (exp_key_valid_o && !ev_prev && ev_had_high)
        check("start_low_gap_ge2", KW'(ev_low_run >= 2), KW'(1));
      if (exp_key_valid_o) begin
        ev_had_high = 1'b1;
        ev_low_run = 0;
      end else begin
        ev_low_run++;
      end
      ev_prev = exp_key_valid_o;
    end
  end

  // Engine model: valid eng_delay cycles after a start edge (0 = never);
  // eng_stale keeps a stale valid level high before and for that many cycles into a job.
  int   eng_delay = 55;
  int   eng_stale = 0;
  logic eng_flush = 1'b0;
  int   eng_cnt = 0;
  int   eng_hold = 0;
  logic eng_prev = 1'b0;
  always @(negedge clk) begin
    if (flush_i) flush_i = 1'b0;
    if (exp_key_valid_o && !eng_prev) begin
      eng_cnt = 1;
      eng_hold = eng_stale;
      if (eng_hold == 0) exp_keys_valid_i = 1'b0;
    end else begin
      if (eng_hold > 0) begin
        eng_hold--;
        if (eng_hold == 0) exp_keys_valid_i = 1'b0;
      end
      if (eng_cnt > 0) begin
        eng_cnt++;
        if (eng_delay != 0 && eng_cnt == eng_delay) begin
          exp_keys_valid_i = 1'b1;
          if (eng_flush) flush_i = 1'b1;
        end
      end
      if (!exp_key_valid_o && eng_stale > 0) exp_keys_valid_i = 1'b1;
    end
    eng_prev = exp_key_valid_o;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, KW'(done_o), KW'(0));
    check({tag, "_err"}, KW'(err_o), KW'(0));
    check({tag, "_busy"}, KW'(busy_o), KW'(0));
    check({tag, "_owner"}, KW'(owner_o), KW'(0));
    check({tag, "_owner_valid"}, KW'(owner_valid_o), KW'(0));
    check({tag, "_exp_key_valid"}, KW'(exp_key_valid_o), KW'(0));
    check({tag, "_exp_key"}, exp_key_o, KW'(0));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_i = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Runs until the scoreboard drains; each requester drops req when its pulse is seen
  task automatic wait_done(input int bound, input string name, output logic ev_seen);
    int waited = 0;
    ev_seen = 1'b0;
    while (sb_q.size() != 0 && waited < bound) begin
      @(negedge clk);
      ev_seen = ev_seen | exp_key_valid_o;
      req_i = req_i & ~(done_o | err_o);
      waited++;
    end
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_wait: got %0d responses pending after %0d cycles, required 0", name, sb_q.size(), bound);
      sb_q.delete();
      req_i = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ev;
    key_t ka, kb, kc, kd, ke;
    resetn = 1'b0;
    req_i = 2'b00;
    for (int b = 0; b < 32; b++) ka[KW-1-8*b -: 8] = 8'(b);
    kb = {32{8'hB1}};
    kc = {32{8'hC2}};
    kd = {32{8'hD3}};
    ke = {32{8'hE4}};
    key0_i = '0;
    key1_i = '0;
    do_reset();

    // Miss on requester 0, engine answers after 55 cycles
    key0_i = ka;
    @(negedge clk);
    req_i = 2'b01;
    sb_q.push_back('{2'b01, 2'b00, 1'b0, 1'b1, ka, -1});
    @(negedge clk);
    check("miss_start_valid", KW'(exp_key_valid_o), KW'(1));
    check("miss_start_key", exp_key_o, ka);
    check("miss_busy", KW'(busy_o), KW'(1));
    wait_done(200, "miss0", ev);

    // Hit: same key from requester 1 completes two cycles after sampling
    key1_i = ka;
    @(negedge clk);
    req_i = 2'b10;
    sb_q.push_back('{2'b10, 2'b00, 1'b1, 1'b1, ka, cyc + 2});
    wait_done(20, "hit1", ev);
    check("hit_no_start", KW'(ev), KW'(0));

    // Both requesting after reset: requester 0 first, then 1
    do_reset();
    key0_i = kb;
    key1_i = kc;
    @(negedge clk);
    req_i = 2'b11;
    sb_q.push_back('{2'b01, 2'b00, 1'b0, 1'b1, kb, -1});
    sb_q.push_back('{2'b10, 2'b00, 1'b1, 1'b1, kc, -1});
    wait_done(400, "both", ev);

    // Stale valid in the first WAIT cycles, then silence: timeout error
    eng_delay = 0;
    eng_stale = 2;
    key0_i = kd;
    repeat (2) @(negedge clk);
    req_i = 2'b01;
    sb_q.push_back('{2'b00, 2'b01, 1'b1, 1'b0, kd, cyc + 130});
    @(negedge clk);
    check("timeout_start_valid", KW'(exp_key_valid_o), KW'(1));
    wait_done(300, "timeout", ev);
    eng_stale = 0;

    // Flush coincident with acceptance: done, but ownership left invalid
    eng_delay = 55;
    eng_flush = 1'b1;
    key1_i = ke;
    @(negedge clk);
    req_i = 2'b10;
    sb_q.push_back('{2'b10, 2'b00, 1'b1, 1'b0, ke, -1});
    wait_done(200, "flush", ev);
    eng_flush = 1'b0;
    check("flush_ov_after", KW'(owner_valid_o), KW'(0));

    // Same key again is a miss because the flush invalidated the cache
    key0_i = ke;
    @(negedge clk);
    req_i = 2'b01;
    sb_q.push_back('{2'b01, 2'b00, 1'b0, 1'b1, ke, -1});
    @(negedge clk);
    check("post_flush_miss_start", KW'(exp_key_valid_o), KW'(1));
    wait_done(200, "post_flush", ev);

    // Asynchronous reset in the middle of WAIT
    eng_delay = 0;
    key1_i = ka;
    @(negedge clk);
    req_i = 2'b10;
    repeat (10) @(negedge clk);
    check("pre_async_busy", KW'(busy_o), KW'(1));
    #2 resetn = 1'b0;
    #1 check_reset_vals("async");
    req_i = 2'b00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("post_async_idle", KW'(busy_o), KW'(0));
    check("sb_drained", KW'(sb_q.size()), KW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
